// File: rtl/stage_pkg.sv
// Shared types for the skid-buffered pipeline stage.
// Holds the occupancy-encoded state enum and its width.
package stage_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones until reset.
// Used for the stage performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/stage_skid.sv
// Two-entry skid-buffered pipeline stage with flush.
// Define STAGE_SKID_PERF_EN to build the stall/flush counters.
module stage_skid
    import stage_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CNT_W     = 32,
    parameter int FLUSH_CLR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    stage_st_e        state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    // Ready depends on state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (FLUSH_CLR != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_data  = main_q;
    assign occupancy = state_q;

`ifdef STAGE_SKID_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & (state_q != ST_EMPTY);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (perf_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_skid.sv
// Directed table-driven bench for stage_skid.
// Counter expectations follow STAGE_SKID_PERF_EN.
module tb_stage_skid;

    localparam int W  = 16;
    localparam int CW = 4;
`ifdef STAGE_SKID_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] perf_stall_cnt;
    logic [CW-1:0] perf_flush_cnt;

    int errors = 0;
    int checks = 0;

    stage_skid #(
        .WIDTH     (W),
        .CNT_W     (CW),
        .FLUSH_CLR (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .occupancy      (occupancy),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ev;
        logic         er;
        logic [1:0]   eo;
        logic         cd;
        logic [W-1:0] ed;
        int           es;
        int           ef;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv,
                         input logic [W-1:0] id, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic fl, input logic iv, input int id,
                       input logic ordy, input logic ev, input logic er,
                       input int eo, input logic cd, input int ed,
                       input int es, input int ef);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = W'(id); v.ordy = ordy;
        v.ev = ev; v.er = er; v.eo = 2'(eo); v.cd = cd;
        v.ed = W'(ed); v.es = es; v.ef = ef;
        vq.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // streaming 1..8
        for (int i = 1; i <= 8; i++) add(0, 1, i, 1, 1, 1, 1, 1, i, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        // backpressure A, B, C
        add(0, 1, 'hA, 0, 1, 1, 1, 1, 'hA, 0, 0);
        add(0, 1, 'hB, 0, 1, 0, 2, 1, 'hA, 1, 0);
        add(0, 1, 'hC, 0, 1, 0, 2, 1, 'hA, 2, 0);
        add(0, 1, 'hC, 1, 1, 1, 1, 1, 'hB, 2, 0);
        add(0, 1, 'hC, 1, 1, 1, 1, 1, 'hC, 2, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0);
        // flush from FULL with D offered, then flush while empty
        add(0, 1, 'h1, 0, 1, 1, 1, 1, 'h1, 2, 0);
        add(0, 1, 'h2, 0, 1, 0, 2, 1, 'h1, 3, 0);
        add(1, 1, 'hD, 0, 0, 1, 0, 1, 0, 4, 1);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0, 4, 1);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 4, 1);

        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_occ", occupancy, 0);
        chk("reset_data", out_data, 0);
        chk("reset_stall", perf_stall_cnt, 0);
        chk("reset_flush", perf_flush_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].fl, vq[i].iv, vq[i].id, vq[i].ordy);
            chk($sformatf("row%0d_out_valid", i), out_valid, vq[i].ev);
            chk($sformatf("row%0d_in_ready", i), in_ready, vq[i].er);
            chk($sformatf("row%0d_occ", i), occupancy, vq[i].eo);
            if (vq[i].ev || vq[i].cd)
                chk($sformatf("row%0d_data", i), out_data, vq[i].ed);
            chk($sformatf("row%0d_stall", i), perf_stall_cnt,
                PERF ? vq[i].es : 0);
            chk($sformatf("row%0d_flush", i), perf_flush_cnt,
                PERF ? vq[i].ef : 0);
        end

        // asynchronous reset while FULL
        drive(0, 1, 'h7, 0);
        drive(0, 1, 'h8, 0);
        chk("pre_rst_occ", occupancy, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_stall", perf_stall_cnt, 0);
        chk("async_rst_flush", perf_flush_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 'h5, 1);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 'h5);
        drive(0, 0, 0, 1);
        chk("post_rst_drain", out_valid, 0);

        // stall counter saturation
        drive(0, 1, 'h9, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0);
            if (i == 13) chk("stall_14", perf_stall_cnt, PERF ? 14 : 0);
        end
        chk("stall_sat", perf_stall_cnt, PERF ? 15 : 0);
        chk("stall_sat_data", out_data, 'h9);
        chk("stall_sat_flush", perf_flush_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
